// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default geometry and the address-field width helpers.
package icache_pkg;

   localparam int unsigned DEF_ADDR_WIDTH     = 32;
   localparam int unsigned DEF_DATA_WIDTH     = 32;
   localparam int unsigned DEF_LINES          = 64;
   localparam int unsigned DEF_WORDS_PER_LINE = 4;

   // Word-offset field width within a line.
   function automatic int unsigned offset_width(input int unsigned words_per_line);
      return $clog2(words_per_line);
   endfunction

   // Line-index field width.
   function automatic int unsigned index_width(input int unsigned lines);
      return $clog2(lines);
   endfunction

   // Tag width: everything above index, offset and the byte-in-word bits.
   function automatic int unsigned tag_width(input int unsigned addr_width,
                                             input int unsigned lines,
                                             input int unsigned words_per_line);
      return addr_width - 2 - $clog2(lines) - $clog2(words_per_line);
   endfunction

   localparam int unsigned OFFSET_W = offset_width(DEF_WORDS_PER_LINE);
   localparam int unsigned INDEX_W  = index_width(DEF_LINES);
   localparam int unsigned TAG_W    = tag_width(DEF_ADDR_WIDTH, DEF_LINES, DEF_WORDS_PER_LINE);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REFILL  = 2'd1,
      ST_RESPOND = 2'd2
   } state_e;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data array: one synchronous read port, one write port, no reset.
module icache_data_ram
   import icache_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Registered read every cycle; write when enabled.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: tag/valid lookup, line refill
// over a req/ack memory handshake, fetch stall on miss, whole-cache flush.
module icache_ctrl
   import icache_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned LINES          = DEF_LINES,
   parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_valid,
   output logic                  cpu_stall,
   input  logic                  flush,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned OFF_W  = offset_width(WORDS_PER_LINE);
   localparam int unsigned IDX_W  = index_width(LINES);
   localparam int unsigned TAG_W_L = tag_width(ADDR_WIDTH, LINES, WORDS_PER_LINE);
   localparam int unsigned RAM_AW = IDX_W + OFF_W;

   // Request address fields
   logic [OFF_W-1:0]   req_off;
   logic [IDX_W-1:0]   req_idx;
   logic [TAG_W_L-1:0] req_tag;
   logic               unused_byte_bits;

   assign req_off          = cpu_addr[2 +: OFF_W];
   assign req_idx          = cpu_addr[2+OFF_W +: IDX_W];
   assign req_tag          = cpu_addr[ADDR_WIDTH-1 -: TAG_W_L];
   assign unused_byte_bits = ^cpu_addr[1:0];

   // State
   state_e               state_q, state_d;
   logic [OFF_W-1:0]     cnt_q, cnt_d;
   logic [TAG_W_L-1:0]   tag_q, tag_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [OFF_W-1:0]     off_q, off_d;
   logic [DATA_WIDTH-1:0] resp_q, resp_d;
   logic                 hit_q, hit_d;
   logic                 pend_q, pend_d;

   logic [LINES-1:0]     valid_q;
   logic [TAG_W_L-1:0]   tag_arr_q [LINES];

   // Control strobes from the next-state logic
   logic                 valid_clr;
   logic                 line_fill;
   logic                 line_set;
   logic                 ram_we;
   logic                 lookup_hit;
   logic                 last_word;

   logic [RAM_AW-1:0]    ram_raddr;
   logic [RAM_AW-1:0]    ram_waddr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign lookup_hit = valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);
   assign last_word  = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
   assign line_set   = line_fill && !pend_q && !flush;
   assign ram_raddr  = {req_idx, req_off};
   assign ram_waddr  = {idx_q, cnt_q};

   icache_data_ram #(
      .ADDR_W     (RAM_AW),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_data_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (mem_rdata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   // Next-state and control decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tag_d     = tag_q;
      idx_d     = idx_q;
      off_d     = off_q;
      resp_d    = resp_q;
      pend_d    = pend_q;
      hit_d     = 1'b0;
      valid_clr = 1'b0;
      line_fill = 1'b0;
      ram_we    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (flush) begin
               valid_clr = 1'b1;
            end
            if (cpu_req) begin
               // A flush in the same cycle forces the lookup to miss.
               if (lookup_hit && !flush) begin
                  hit_d = 1'b1;
               end else begin
                  state_d = ST_REFILL;
                  cnt_d   = '0;
                  tag_d   = req_tag;
                  idx_d   = req_idx;
                  off_d   = req_off;
               end
            end
         end
         ST_REFILL: begin
            if (flush) begin
               pend_d = 1'b1;
            end
            if (mem_ack) begin
               ram_we = 1'b1;
               cnt_d  = cnt_q + OFF_W'(1);
               if (cnt_q == off_q) begin
                  resp_d = mem_rdata;
               end
               if (last_word) begin
                  line_fill = 1'b1;
                  state_d   = ST_RESPOND;
               end
            end
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            if (flush || pend_q) begin
               valid_clr = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers with async active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tag_q   <= '0;
         idx_q   <= '0;
         off_q   <= '0;
         resp_q  <= '0;
         hit_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         resp_q  <= resp_d;
         hit_q   <= hit_d;
         pend_q  <= pend_d;
      end
   end

   // Valid bits: async clear on reset, single-cycle clear on flush
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (valid_clr) begin
         valid_q <= '0;
      end else if (line_set) begin
         valid_q[idx_q] <= 1'b1;
      end
   end

   // Tag array written when a refill completes
   always_ff @(posedge clk) begin
      if (line_fill) begin
         tag_arr_q[idx_q] <= tag_q;
      end
   end

   assign cpu_valid = hit_q || (state_q == ST_RESPOND);
   assign cpu_rdata = hit_q ? ram_rdata : resp_q;
   assign cpu_stall = (state_q == ST_REFILL);
   assign mem_req   = (state_q == ST_REFILL);
   assign mem_addr  = mem_req ? {tag_q, idx_q, cnt_q, 2'b00} : '0;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a word-addressed backing-memory model
// and a scoreboard of expected fetch data and refill addresses.
module tb_icache_ctrl;

   logic        clk;
   logic        reset;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_rdata;
   logic        cpu_valid;
   logic        cpu_stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [31:0] exp_data_q [$];
   logic [31:0] exp_addr_q [$];
   int unsigned line_ver [int unsigned];

   int unsigned mem_ver   = 0;
   int unsigned ack_delay = 0;
   bit          noise     = 0;
   int unsigned acks_done = 0;

   icache_ctrl #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .LINES          (64),
      .WORDS_PER_LINE (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_rdata (cpu_rdata),
      .cpu_valid (cpu_valid),
      .cpu_stall (cpu_stall),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backing memory content: word in line, line offset from 0x40, version.
   function automatic logic [31:0] mem_data(input logic [31:0] a, input int unsigned v);
      logic [31:0] t;
      t = a >> 4;
      return (32'(v) << 24) + ((t - 32'd4) << 8) + 32'h0000_00A0 + {30'd0, a[3:2]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory responder: acks after ack_delay wait cycles, spurious acks while idle.
   initial begin
      int unsigned wait_cnt;
      wait_cnt  = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_data(mem_addr, mem_ver);
               wait_cnt  = 0;
               check("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
               if (exp_addr_q.size() != 0) begin
                  check("mem_addr", mem_addr, exp_addr_q.pop_front());
               end
            end else begin
               mem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            wait_cnt  = 0;
            mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
         end
      end
   end

   // Accepted-ack counter used to time mid-refill events.
   initial begin
      forever begin
         @(posedge clk);
         if (reset === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
            acks_done++;
         end
      end
   end

   // Output monitor: invariants every cycle, scoreboard pop on cpu_valid.
   initial begin
      forever begin
         @(negedge clk);
         check("stall_valid_excl", {31'd0, cpu_stall & cpu_valid}, 32'd0);
         check("req_only_refill", {31'd0, mem_req}, {31'd0, cpu_stall});
         if (cpu_valid === 1'b1) begin
            check("sb_expected", 32'(exp_data_q.size() != 0), 32'd1);
            if (exp_data_q.size() != 0) begin
               check("cpu_rdata", cpu_rdata, exp_data_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic miss(input logic [31:0] a, input int unsigned dly, input bit flush_req,
                       input int unsigned flush_at, input string tag);
      int unsigned base;
      int unsigned cyc;
      bit          stall_ok;
      bit          fdone;
      logic [31:0] line;
      line      = a & 32'hFFFF_FFF0;
      ack_delay = dly;
      for (int w = 0; w < 4; w++) begin
         exp_addr_q.push_back(line + 32'(4 * w));
      end
      exp_data_q.push_back(mem_data({a[31:2], 2'b00}, mem_ver));
      line_ver[int'(line >> 4)] = mem_ver;
      base     = acks_done;
      cpu_req  = 1'b1;
      cpu_addr = a;
      flush    = flush_req;
      @(negedge clk);
      flush    = 1'b0;
      cpu_addr = a ^ 32'h0000_0FF0;
      check({tag, "_stall"}, {31'd0, cpu_stall}, 32'd1);
      check({tag, "_memreq"}, {31'd0, mem_req}, 32'd1);
      cyc      = 1;
      stall_ok = 1'b1;
      fdone    = 1'b0;
      while (cpu_valid !== 1'b1 && cyc < 200) begin
         if (cpu_stall !== 1'b1) stall_ok = 1'b0;
         @(negedge clk);
         cyc++;
         if (flush_at != 0 && !fdone && (acks_done - base) == flush_at) begin
            flush = 1'b1;
            fdone = 1'b1;
         end else begin
            flush = 1'b0;
         end
      end
      cpu_req = 1'b0;
      flush   = 1'b0;
      check({tag, "_latency"}, cyc, 4 * (dly + 1) + 1);
      check({tag, "_stall_held"}, {31'd0, stall_ok}, 32'd1);
      check({tag, "_stall_low"}, {31'd0, cpu_stall}, 32'd0);
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, cpu_valid}, 32'd0);
   endtask

   task automatic hit2(input logic [31:0] a, input logic [31:0] b, input string tag);
      exp_data_q.push_back(mem_data(a, line_ver[int'(a >> 4)]));
      exp_data_q.push_back(mem_data(b, line_ver[int'(b >> 4)]));
      cpu_req  = 1'b1;
      cpu_addr = a;
      @(negedge clk);
      check({tag, "_v0"}, {31'd0, cpu_valid}, 32'd1);
      check({tag, "_noreq0"}, {31'd0, mem_req}, 32'd0);
      cpu_addr = b;
      @(negedge clk);
      check({tag, "_v1"}, {31'd0, cpu_valid}, 32'd1);
      check({tag, "_noreq1"}, {31'd0, mem_req}, 32'd0);
      cpu_req = 1'b0;
      @(negedge clk);
      check({tag, "_vend"}, {31'd0, cpu_valid}, 32'd0);
   endtask

   initial begin
      int unsigned base;
      int unsigned cyc;
      reset    = 1'b1;
      cpu_req  = 1'b0;
      cpu_addr = '0;
      flush    = 1'b0;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, cpu_valid}, 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_stall", {31'd0, cpu_stall}, 32'd0);
      check("rst_memreq", {31'd0, mem_req}, 32'd0);
      check("rst_memaddr", mem_addr, 32'd0);
      reset = 1'b1;
      noise = 1'b1;
      @(negedge clk);

      // Cold miss, memory acking with one wait cycle
      miss(32'h0000_0048, 1, 1'b0, 0, "cold");
      hit2(32'h0000_0044, 32'h0000_004C, "hit");

      // Conflict on index 4, then the evicted line misses again
      mem_ver = 1;
      miss(32'h0000_0440, 0, 1'b0, 0, "conflict");
      miss(32'h0000_0040, 0, 1'b0, 0, "reload");
      hit2(32'h0000_0048, 32'h0000_004C, "hit_reload");

      // Flush together with a request that would otherwise hit
      mem_ver = 2;
      miss(32'h0000_0044, 2, 1'b1, 0, "flush_idle");
      hit2(32'h0000_0040, 32'h0000_004C, "hit_after_fi");

      // Flush raised after the second ack of a refill
      mem_ver = 3;
      flush   = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      miss(32'h0000_004C, 0, 1'b0, 2, "flush_refill");
      mem_ver = 4;
      miss(32'h0000_0040, 0, 1'b0, 0, "after_flush");
      hit2(32'h0000_0044, 32'h0000_0048, "hit_after_fr");

      // Reset dropped mid-refill
      mem_ver   = 5;
      ack_delay = 0;
      for (int w = 0; w < 4; w++) begin
         exp_addr_q.push_back(32'h0000_0840 + 32'(4 * w));
      end
      base     = acks_done;
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_0840;
      @(negedge clk);
      cpu_req = 1'b0;
      cyc     = 0;
      while ((acks_done - base) < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("rstmid_acks", acks_done - base, 32'd2);
      reset = 1'b0;
      #1;
      check("rstmid_memreq", {31'd0, mem_req}, 32'd0);
      check("rstmid_stall", {31'd0, cpu_stall}, 32'd0);
      check("rstmid_memaddr", mem_addr, 32'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      miss(32'h0000_0040, 0, 1'b0, 0, "post_reset");

      repeat (2) @(negedge clk);
      check("sb_data_drained", exp_data_q.size(), 32'd0);
      check("sb_addr_drained", exp_addr_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache controller sitting between the fetch stage (PC) and a slower backing instruction memory. It holds the tag/valid array, sequences line refills over a req/ack memory handshake, and stalls fetch on a miss. Hits return the instruction one cycle after the request, matching the existing fetch timing. It also provides a whole-cache invalidate for program reload.

## Interface
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: instruction/word width.
- LINES, 64: number of cache lines; power of two.
- WORDS_PER_LINE, 4: words per line; power of two, ≥2.

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- cpu_req  in  1  fetch request; sampled only when not stalled.
- cpu_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- cpu_rdata  out  DATA_WIDTH  fetched instruction; qualified by cpu_valid.
- cpu_valid  out  1  one-cycle pulse, cpu_rdata valid.
- cpu_stall  out  1  miss in progress; fetch must hold PC.
- flush  in  1  invalidate all lines.
- mem_req  out  1  backing-memory word read request (level).
- mem_addr  out  ADDR_WIDTH  word-aligned read address.
- mem_ack  in  1  read data valid; meaningful only while mem_req=1.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.

## Operation
- Address split: word offset = addr[2 +: log2(WORDS_PER_LINE)], index = next log2(LINES) bits, tag = remaining upper bits. Defaults: offset [3:2], index [9:4], tag [31:10].
- FSM states: IDLE, REFILL, RESPOND.
- IDLE: on cpu_req, latch address. Read tag/valid combinationally and issue a synchronous data-array read.
  - Hit (valid && tag match): stay IDLE; next cycle cpu_valid=1 with the data word.
  - Miss: go to REFILL; cpu_stall=1 from the next cycle.
- REFILL: word counter runs 0..WORDS_PER_LINE-1, always starting at word 0 (no critical-word-first).
  - mem_req=1, mem_addr = {tag, index, cnt, 2'b00}.
  - Each mem_ack writes mem_rdata into the data array at (index, cnt) and increments cnt. mem_addr updates the cycle after the ack; mem_req stays high between words.
  - When cnt equals the requested offset, capture mem_rdata into the response register.
  - On the final ack: mem_req drops the next cycle; write the tag; set valid unless a flush is pending; go to RESPOND.
- RESPOND: one cycle with cpu_valid=1, cpu_rdata = captured word, cpu_stall=0. Then IDLE. A cpu_req in this cycle is ignored; fetch re-presents it.
- Flush:
  - In IDLE: clear all valid bits that cycle. A concurrent cpu_req is treated as a miss.
  - In REFILL or RESPOND: set pending_flush. The refill completes and the word is delivered, but the line is not marked valid. All valid bits clear on return to IDLE.
- cpu_req and cpu_addr changes while cpu_stall=1 are ignored.
- mem_ack while mem_req=0 is ignored.
- Reset (async, any state): FSM→IDLE, all valid bits=0, cnt=0, pending_flush=0. The data array is not cleared.

## Timing
- Reset values: cpu_valid=0, cpu_rdata=0, cpu_stall=0, mem_req=0, mem_addr=0.
- Hit latency: request at cycle N → cpu_valid at N+1.
- Back-to-back hits sustain one per cycle.
- Miss: request at N → cpu_stall=1 and mem_req=1 from N+1.
- With memory acking every cycle, the last ack lands at N+WORDS_PER_LINE and cpu_valid is at N+WORDS_PER_LINE+1. Each extra ack wait cycle adds one.
- cpu_stall and cpu_valid are never both 1.
- mem_req is never 1 outside REFILL.

## Structure
- Shared header/package icache_pkg: FSM state encoding localparams and the derived field widths (OFFSET_W, INDEX_W, TAG_W).
- Sub-module icache_data_ram: LINES*WORDS_PER_LINE × DATA_WIDTH, one synchronous read port, one write port, no reset.
- Tag and valid arrays stay in icache_ctrl as registers; valid needs async clear and single-cycle flush.

## Test plan
- Cold miss: after reset, request 0x0000_0048; memory acks with 1-cycle delay returning 0xA0..0xA3. Required: mem_addr 0x40, 0x44, 0x48, 0x4C in order; stall throughout; cpu_valid with 0xA2; stall low.
- Hit: then request 0x44, 0x4C on consecutive cycles. Required: cpu_valid on the next two cycles with 0xA1, 0xA3; mem_req stays 0.
- Conflict: request 0x0000_0440 (index 4, new tag). Required: refill 0x440–0x44C. A following request to 0x40 misses again.
- Flush in IDLE: flush=1 together with request 0x44. Required: treated as a miss; full refill of 0x40 line.
- Flush during refill: assert flush after the 2nd ack of the 0x40 refill. Required: word still delivered; the next request to 0x40 misses.
- Reset mid-refill: drop reset after the 2nd ack. Required: mem_req=0 and cpu_stall=0 immediately. After reset release, request 0x40 refills starting at mem_addr 0x40.
